sram_req_arbiter: RTL and testbench



---
 rtl/sram_req_arbiter_pkg.sv | 30 +++
 rtl/arb_route_fifo.sv | 66 ++++++
 rtl/sram_req_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_req_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the SRAM-like request arbiter: bus widths, size
// encodings, requester ids and the request payload struct.
package sram_req_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 2;

  // Transfer size encodings on the size field.
  typedef enum logic [SIZE_W-1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // Requester ids as stored in the route FIFO.
  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  // Request fields muxed from the selected master to the slave port.
  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/arb_route_fifo.sv
// In-order route FIFO: one requester-id bit per accepted request.
// Ports: clk, rst_n (async, active-low); push/push_id write a new owner id,
// pop retires the head; head is the oldest owner id; full/empty status.
module arb_route_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next-state: pointers wrap naturally at DEPTH (power of two).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Two-to-one round-robin arbiter for an SRAM-like request port.
// Ports: aclk/aresetn (async active-low); m0_*/m1_* master request inputs with
// addr_ok/data_ok/rdata responses; s_* muxed request to the slave with its
// addr_ok/data_ok/rdata returns; err is a sticky flag for data_ok with nothing
// outstanding. Request and response paths are combinational.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [SIZE_W-1:0] m0_size,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [STRB_W-1:0] m0_wstrb,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_addr_ok,
  output logic              m0_data_ok,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [SIZE_W-1:0] m1_size,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [STRB_W-1:0] m1_wstrb,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_addr_ok,
  output logic              m1_data_ok,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_req,
  output logic              s_wr,
  output logic [SIZE_W-1:0] s_size,
  output logic [ADDR_W-1:0] s_addr,
  output logic [STRB_W-1:0] s_wstrb,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              err
);

  logic      gnt_q, gnt_d;
  logic      lock_q, lock_d;
  logic      last_q, last_d;
  logic      err_q, err_d;
  logic      sel;
  logic      sel_req;
  logic      accept;
  logic      resp_ok;
  logic      fifo_full, fifo_empty, fifo_head;
  sram_req_t m0_pl, m1_pl, sel_pl;

  assign m0_pl = '{wr: m0_wr, size: m0_size, addr: m0_addr, wstrb: m0_wstrb, wdata: m0_wdata};
  assign m1_pl = '{wr: m1_wr, size: m1_size, addr: m1_addr, wstrb: m1_wstrb, wdata: m1_wdata};

  // Selection: locked grant wins; otherwise round-robin against last accept.
  always_comb begin
    sel = gnt_q;
    if (!lock_q) begin
      if (m0_req && m1_req) begin
        sel = ~last_q;
      end else if (m0_req) begin
        sel = ARB_M0;
      end else if (m1_req) begin
        sel = ARB_M1;
      end
    end
  end

  assign sel_pl  = (sel == ARB_M1) ? m1_pl : m0_pl;
  assign sel_req = (sel == ARB_M1) ? m1_req : m0_req;

  // Request path; reset gating keeps handshakes low while aresetn is low.
  assign s_req   = aresetn & sel_req & ~fifo_full;
  assign s_wr    = sel_pl.wr;
  assign s_size  = sel_pl.size;
  assign s_addr  = sel_pl.addr;
  assign s_wstrb = sel_pl.wstrb;
  assign s_wdata = sel_pl.wdata;

  assign accept     = s_req & s_addr_ok;
  assign m0_addr_ok = accept & (sel == ARB_M0);
  assign m1_addr_ok = accept & (sel == ARB_M1);

  // Response path routed by the oldest outstanding owner.
  assign resp_ok    = aresetn & s_data_ok & ~fifo_empty;
  assign m0_data_ok = resp_ok & (fifo_head == ARB_M0);
  assign m1_data_ok = resp_ok & (fifo_head == ARB_M1);
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;

  assign err = err_q;

  // Lock holds the presented request across slave back-pressure.
  always_comb begin
    gnt_d  = sel;
    lock_d = lock_q;
    last_d = last_q;
    err_d  = err_q | (s_data_ok & fifo_empty);
    if (accept) begin
      lock_d = 1'b0;
      last_d = sel;
    end else if (s_req) begin
      lock_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      gnt_q  <= 1'b0;
      lock_q <= 1'b0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      lock_q <= lock_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

  arb_route_fifo #(
    .DEPTH (DEPTH)
  ) u_route_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .push    (accept),
    .push_id (sel),
    .pop     (resp_ok),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed, table-driven bench for sram_req_arbiter (DEPTH = 4).
module tb_sram_req_arbiter;
  import sram_req_arbiter_pkg::*;

  logic              aclk;
  logic              aresetn;
  logic              m0_req, m1_req, m0_wr, m1_wr;
  logic [SIZE_W-1:0] m0_size, m1_size;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [STRB_W-1:0] m0_wstrb, m1_wstrb;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              s_req, s_wr;
  logic [SIZE_W-1:0] s_size;
  logic [ADDR_W-1:0] s_addr;
  logic [STRB_W-1:0] s_wstrb;
  logic [DATA_W-1:0] s_wdata;
  logic              s_addr_ok, s_data_ok;
  logic [DATA_W-1:0] s_rdata;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  sram_req_arbiter #(.DEPTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata),
    .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata),
    .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
    .s_wstrb(s_wstrb), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .err(err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        m0_req;
    logic        m1_req;
    logic        s_addr_ok;
    logic        s_data_ok;
    logic [31:0] s_rdata;
    logic        e_m0_aok;
    logic        e_m1_aok;
    logic        e_m0_dok;
    logic        e_m1_dok;
    logic        e_sreq;
    logic [31:0] e_saddr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m1_req = 0; s_addr_ok = 0; s_data_ok = 0; s_rdata = '0;
  endtask

  vec_t vecs[6];

  initial begin
    aresetn  = 0;
    m0_wr = 0; m1_wr = 1;
    m0_size = SIZE_WORD; m1_size = SIZE_WORD;
    m0_addr = 32'h0000_00A0; m1_addr = 32'h0000_00B0;
    m0_wstrb = 4'h0; m1_wstrb = 4'hF;
    m0_wdata = 32'h0; m1_wdata = 32'h1234_5678;
    idle_inputs();

    // Round-robin stream with last=0; data_ok trails addr_ok by one cycle.
    vecs[0] = '{1, 1, 1, 0, 32'h0,         0, 1, 0, 0, 1, 32'h0000_00B0};
    vecs[1] = '{1, 1, 1, 1, 32'h1111_0001, 1, 0, 0, 1, 1, 32'h0000_00A0};
    vecs[2] = '{1, 1, 1, 1, 32'h2222_0002, 0, 1, 1, 0, 1, 32'h0000_00B0};
    vecs[3] = '{1, 1, 1, 1, 32'h3333_0003, 1, 0, 0, 1, 1, 32'h0000_00A0};
    vecs[4] = '{0, 0, 0, 1, 32'h4444_0004, 0, 0, 1, 0, 0, 32'h0};
    vecs[5] = '{0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0};

    // Reset state
    #12;
    check("rst s_req", s_req, 0);
    check("rst err", err, 0);
    check("rst m0_addr_ok", m0_addr_ok, 0);
    aresetn = 1;
    step();

    // Single m0 read, data 2 cycles after the accept
    m0_addr = 32'h0000_1000; m0_req = 1; s_addr_ok = 1; #1;
    check("t1 s_req", s_req, 1);
    check("t1 s_addr", s_addr, 32'h0000_1000);
    check("t1 m0_addr_ok", m0_addr_ok, 1);
    check("t1 m1_addr_ok", m1_addr_ok, 0);
    step();
    idle_inputs();
    step();
    s_data_ok = 1; s_rdata = 32'hDEAD_BEEF; #1;
    check("t1 m0_data_ok", m0_data_ok, 1);
    check("t1 m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("t1 m1_data_ok", m1_data_ok, 0);
    step();
    idle_inputs();
    m0_addr = 32'h0000_00A0;
    step();

    // Table-driven round-robin and routing
    for (int i = 0; i < 6; i++) begin
      m0_req = vecs[i].m0_req; m1_req = vecs[i].m1_req;
      s_addr_ok = vecs[i].s_addr_ok; s_data_ok = vecs[i].s_data_ok;
      s_rdata = vecs[i].s_rdata; #1;
      check($sformatf("vec%0d m0_addr_ok", i), m0_addr_ok, vecs[i].e_m0_aok);
      check($sformatf("vec%0d m1_addr_ok", i), m1_addr_ok, vecs[i].e_m1_aok);
      check($sformatf("vec%0d m0_data_ok", i), m0_data_ok, vecs[i].e_m0_dok);
      check($sformatf("vec%0d m1_data_ok", i), m1_data_ok, vecs[i].e_m1_dok);
      check($sformatf("vec%0d s_req", i), s_req, vecs[i].e_sreq);
      if (vecs[i].e_sreq) check($sformatf("vec%0d s_addr", i), s_addr, vecs[i].e_saddr);
      if (vecs[i].e_m0_dok) check($sformatf("vec%0d m0_rdata", i), m0_rdata, vecs[i].s_rdata);
      if (vecs[i].e_m1_dok) check($sformatf("vec%0d m1_rdata", i), m1_rdata, vecs[i].s_rdata);
      step();
    end
    idle_inputs();

    // Make last=1 so an unlocked arbiter would switch to m0 below
    m1_req = 1; s_addr_ok = 1; #1;
    check("pre m1_addr_ok", m1_addr_ok, 1);
    step();
    idle_inputs(); s_data_ok = 1; #1;
    check("pre m1_data_ok", m1_data_ok, 1);
    step();
    idle_inputs();

    // Back-pressure lock: m1 address must stay presented for 4 cycles
    m0_addr = 32'h0000_3000; m1_addr = 32'h0000_2000;
    m1_req = 1; #1;
    check("lock c0 s_req", s_req, 1);
    check("lock c0 s_addr", s_addr, 32'h0000_2000);
    check("lock c0 m1_addr_ok", m1_addr_ok, 0);
    step();
    m0_req = 1;
    for (int c = 1; c < 3; c++) begin
      #1;
      check($sformatf("lock c%0d s_addr", c), s_addr, 32'h0000_2000);
      check($sformatf("lock c%0d s_req", c), s_req, 1);
      step();
    end
    s_addr_ok = 1; #1;
    check("lock c3 s_addr", s_addr, 32'h0000_2000);
    check("lock c3 m1_addr_ok", m1_addr_ok, 1);
    check("lock c3 m0_addr_ok", m0_addr_ok, 0);
    step();
    m1_req = 0; #1;
    check("lock m0 accept", m0_addr_ok, 1);
    check("lock m0 s_addr", s_addr, 32'h0000_3000);
    step();
    idle_inputs(); s_data_ok = 1; #1;
    check("lock resp0 m1", m1_data_ok, 1);
    check("lock resp0 m0", m0_data_ok, 0);
    step();
    #1;
    check("lock resp1 m0", m0_data_ok, 1);
    check("lock resp1 m1", m1_data_ok, 0);
    step();
    idle_inputs();

    // FIFO full back-pressure (DEPTH = 4)
    m0_req = 1; s_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("full acc%0d", k), m0_addr_ok, 1);
      step();
    end
    #1;
    check("full s_req held", s_req, 0);
    check("full no addr_ok", m0_addr_ok, 0);
    step();
    s_data_ok = 1; #1;
    check("full pop data_ok", m0_data_ok, 1);
    check("full pop s_req", s_req, 0);
    step();
    s_data_ok = 0; #1;
    check("full 5th accept", m0_addr_ok, 1);
    step();
    s_data_ok = 1; #1;
    check("full again s_req", s_req, 0);
    step();
    #1;
    check("simul accept", m0_addr_ok, 1);
    check("simul data_ok", m0_data_ok, 1);
    step();
    s_data_ok = 0; #1;
    check("refill accept", m0_addr_ok, 1);
    step();
    #1;
    check("refill full s_req", s_req, 0);
    step();
    m0_req = 0; s_addr_ok = 0; s_data_ok = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("drain%0d m0_data_ok", k), m0_data_ok, 1);
      step();
    end

    // data_ok with nothing outstanding
    #1;
    check("err pre", err, 0);
    check("err m0_data_ok", m0_data_ok, 0);
    check("err m1_data_ok", m1_data_ok, 0);
    step();
    s_data_ok = 0; #1;
    check("err set", err, 1);
    step();
    #1;
    check("err sticky", err, 1);

    // Asynchronous reset with two outstanding
    m0_req = 1; s_addr_ok = 1;
    step(); step();
    s_data_ok = 1; #1;
    check("pre-rst m0_data_ok", m0_data_ok, 1);
    #1;
    aresetn = 0; #1;
    check("arst s_req", s_req, 0);
    check("arst m0_addr_ok", m0_addr_ok, 0);
    check("arst m0_data_ok", m0_data_ok, 0);
    check("arst m1_data_ok", m1_data_ok, 0);
    check("arst err", err, 0);
    m0_req = 0; s_addr_ok = 0;
    #10;
    aresetn = 1; #1;
    check("post-rst empty", m0_data_ok, 0);
    step();
    s_data_ok = 0; #1;
    check("post-rst err", err, 1);
    idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
